nw_fill_engine: RTL and testbench
=================================

# nw_fill_engine

Self-sequencing Needleman-Wunsch matrix fill engine, the parametrised successor of the signal-management layer. It replaces the separate initialization counter, insertion counter, match/mismatch and max blocks with one FSM. The FSM initializes row 0 and column 0, walks every interior cell, fetches neighbour scores and sequence symbols, and writes back score plus traceback symbol. Score width, sequence length and alphabet width are parameters. Gap, match and mismatch scores and both sequence lengths are programmable at run time. It sits between the top-level controller (start/done) and the score/traceback RAMs and sequence ROMs.

## Interface
Parameters:
- N, 128, maximum sequence length per axis
- AW, $clog2(N+1), row/column index width
- W, 9, signed score width
- SYM_W, 3, alphabet symbol width
- DEF_GAP / DEF_MATCH / DEF_MISMATCH, -2 / 1 / -1, scores used when cfg_use_def=1

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin run; sampled only in IDLE
- cfg_use_def  in  1  1: use DEF_* parameters; 0: use cfg_* ports
- cfg_gap, cfg_match, cfg_mismatch  in  W signed  run-time scores, latched at start
- len_a, len_b  in  AW  sequence lengths, latched at start, clamped to N
- stall  in  1  freezes FSM and all registers while high
- a, b  in  SYM_W  symbols a[i-1], b[j-1]; valid the cycle after rd_en
- diag, up, left  in  W signed  scores (i-1,j-1), (i-1,j), (i,j-1); valid the cycle after rd_en
- rd_en  out  1  read strobe for RAM/ROM at (i, j)
- i, j  out  AW  current cell coordinates
- wr_en  out  1  write strobe
- wr_score  out  W signed  score to write at (i, j)
- wr_sym  out  3  traceback: bit2 diag, bit1 up, bit0 left
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of run
- final_score  out  W signed  score of cell (len_a, len_b), held until next start

## Operation
- States: IDLE, INIT_COL, INIT_ROW, RD, CALC, WR, DONE.
- IDLE, start=1:
  - latch scores (per cfg_use_def) and clamped lengths
  - i=0, j=0 → INIT_COL
- INIT_COL:
  - one write per cycle at (i, 0), i=0..len_a
  - wr_score = i·gap; wr_sym = 010 (000 at (0,0))
  - after i=len_a: i=0, j=1 → INIT_ROW, or → DONE if len_b=0
- INIT_ROW:
  - one write per cycle at (0, j), j=1..len_b; wr_score = j·gap; wr_sym = 001
  - after j=len_b: i=1, j=1 → RD, or → DONE if len_a=0
- RD: rd_en=1 → CALC.
- CALC: register the cell result:
  - s = (a==b) ? match : mismatch
  - cD = diag+s, cU = up+gap, cL = left+gap
  - max = largest of cD, cU, cL
  - wr_sym bit set for every candidate equal to max (ties set multiple bits)
  - → WR
- WR:
  - wr_en=1; if (i,j)=(len_a,len_b), load final_score
  - advance row-major: j+1; at j=len_b, j=1 and i+1
  - → RD, or → DONE after the last cell
- DONE: done=1 for one cycle → IDLE; i, j hold their last values.
- Arithmetic:
  - k·gap, the additions and the comparisons use W+AW+1 internal bits
  - all results saturate to [-2^(W-1), 2^(W-1)-1] before compare/write
- start while busy: ignored. stall=1: no state, counter or strobe change; rd_en/wr_en forced low while stalled.
- Reset (any time, including mid-run):
  - state IDLE
  - i, j, rd_en, wr_en, wr_score, wr_sym, busy, done, final_score all 0
  - latched config = DEF_*, lengths 0

## Timing
- start sampled at edge t0; busy rises at t0+1.
- INIT occupies len_a+1+len_b cycles; each interior cell occupies 3 cycles (RD, CALC, WR).
- done is high in cycle t0 + 1 + (len_a+1+len_b) + 3·len_a·len_b (unstalled); busy falls on the next edge.
- Read latency fixed at 1: a, b, diag, up, left are sampled in CALC.
- Each stall cycle adds exactly one cycle to total latency.

## Test plan
- Reset then len_a=len_b=1, a=b=2, defaults:
  - writes (0,0)=0/000, (1,0)=-2/010, (0,1)=-2/001, then (1,1)=1/100
  - done at t0+7; final_score=1
- len_a=2, len_b=3, cfg_gap=-1, cfg_match=2, cfg_mismatch=-3, cfg_use_def=0:
  - sequence AGT/AG checked against a golden model for every write, order and count (6 init + 6 cells)
  - done at t0+1+6+18
- Tie: diag=0, up=1, left=1, mismatch, defaults → wr_score=-1, wr_sym=111.
- Saturation, W=9: INIT with len_a=128, gap=-3 → rows with i≥86 write -256; diag=255 with match → 255.
- len_b=0, len_a=4 → 5 column writes, no RD cycles, done at t0+6; start pulsed while busy has no effect.
- Stall and reset:
  - 5-cycle stall during CALC → result unchanged, done delayed by 5
  - rst asserted mid-fill → all outputs 0 asynchronously, FSM IDLE; new start runs cleanly

Source files
------------

// File: rtl/nw_fill_engine.sv
// rtl/nw_fill_engine.sv - Needleman-Wunsch matrix fill sequencer with saturating score datapath
`timescale 1ns/1ps
module nw_fill_engine #(
    parameter int N            = 128,
    parameter int AW           = $clog2(N + 1),
    parameter int W            = 9,
    parameter int SYM_W        = 3,
    parameter int DEF_GAP      = -2,
    parameter int DEF_MATCH    = 1,
    parameter int DEF_MISMATCH = -1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cfg_use_def,
    input  logic signed [W-1:0]  cfg_gap,
    input  logic signed [W-1:0]  cfg_match,
    input  logic signed [W-1:0]  cfg_mismatch,
    input  logic [AW-1:0]        len_a,
    input  logic [AW-1:0]        len_b,
    input  logic                 stall,
    input  logic [SYM_W-1:0]     a,
    input  logic [SYM_W-1:0]     b,
    input  logic signed [W-1:0]  diag,
    input  logic signed [W-1:0]  up,
    input  logic signed [W-1:0]  left,
    output logic                 rd_en,
    output logic [AW-1:0]        i,
    output logic [AW-1:0]        j,
    output logic                 wr_en,
    output logic signed [W-1:0]  wr_score,
    output logic [2:0]           wr_sym,
    output logic                 busy,
    output logic                 done,
    output logic signed [W-1:0]  final_score
);

    localparam int IW = W + AW + 1;
    localparam logic signed [IW-1:0] SMAX = IW'((1 << (W - 1)) - 1);
    localparam logic signed [IW-1:0] SMIN = IW'(-(1 << (W - 1)));
    localparam logic [AW-1:0] NMAX = AW'(N);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_COL, S_INIT_ROW, S_RD, S_CALC, S_WR, S_DONE
    } state_t;

    state_t state, state_n;

    logic [AW-1:0]        i_n, j_n, la, lb;
    logic signed [W-1:0]  gap_r, match_r, mis_r;
    logic signed [W-1:0]  res_score;
    logic [2:0]           res_sym;
    logic                 load_cfg, calc_en, load_final;

    function automatic logic signed [IW-1:0] ext(input logic signed [W-1:0] x);
        return IW'(x);
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [IW-1:0] v);
        if (v > SMAX)      return SMAX[W-1:0];
        else if (v < SMIN) return SMIN[W-1:0];
        else               return v[W-1:0];
    endfunction

    // Boundary score k*gap, k being the row index in INIT_COL and column index in INIT_ROW
    logic [AW-1:0]        k_idx;
    logic signed [IW-1:0] kg;
    logic signed [W-1:0]  init_score;

    always_comb begin
        k_idx      = (state == S_INIT_ROW) ? j : i;
        kg         = $signed({{(IW - AW){1'b0}}, k_idx}) * ext(gap_r);
        init_score = sat(kg);
    end

    logic signed [W-1:0] s_sel, cd, cu, cl, mx;
    logic [2:0]          sym;

    always_comb begin
        s_sel = (a == b) ? match_r : mis_r;
        cd    = sat(ext(diag) + ext(s_sel));
        cu    = sat(ext(up) + ext(gap_r));
        cl    = sat(ext(left) + ext(gap_r));
        mx    = cd;
        if (cu > mx) mx = cu;
        if (cl > mx) mx = cl;
        sym   = {cd == mx, cu == mx, cl == mx};
    end

    always_comb begin
        state_n    = state;
        i_n        = i;
        j_n        = j;
        load_cfg   = 1'b0;
        calc_en    = 1'b0;
        load_final = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_cfg = 1'b1;
                    i_n      = '0;
                    j_n      = '0;
                    state_n  = S_INIT_COL;
                end
            end
            S_INIT_COL: begin
                if (i == la) begin
                    if (lb == '0) begin
                        state_n = S_DONE;
                    end else begin
                        i_n     = '0;
                        j_n     = AW'(1);
                        state_n = S_INIT_ROW;
                    end
                end else begin
                    i_n = i + 1'b1;
                end
            end
            S_INIT_ROW: begin
                if (j == lb) begin
                    if (la == '0) begin
                        state_n = S_DONE;
                    end else begin
                        i_n     = AW'(1);
                        j_n     = AW'(1);
                        state_n = S_RD;
                    end
                end else begin
                    j_n = j + 1'b1;
                end
            end
            S_RD:   state_n = S_CALC;
            S_CALC: begin
                calc_en = 1'b1;
                state_n = S_WR;
            end
            S_WR: begin
                if (j == lb) begin
                    if (i == la) begin
                        load_final = 1'b1;
                        state_n    = S_DONE;
                    end else begin
                        j_n     = AW'(1);
                        i_n     = i + 1'b1;
                        state_n = S_RD;
                    end
                end else begin
                    j_n     = j + 1'b1;
                    state_n = S_RD;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (stall) begin
            state_n    = state;
            i_n        = i;
            j_n        = j;
            load_cfg   = 1'b0;
            calc_en    = 1'b0;
            load_final = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            i           <= '0;
            j           <= '0;
            la          <= '0;
            lb          <= '0;
            gap_r       <= W'(DEF_GAP);
            match_r     <= W'(DEF_MATCH);
            mis_r       <= W'(DEF_MISMATCH);
            res_score   <= '0;
            res_sym     <= '0;
            final_score <= '0;
        end else begin
            state <= state_n;
            i     <= i_n;
            j     <= j_n;
            if (load_cfg) begin
                la      <= (len_a > NMAX) ? NMAX : len_a;
                lb      <= (len_b > NMAX) ? NMAX : len_b;
                gap_r   <= cfg_use_def ? W'(DEF_GAP)      : cfg_gap;
                match_r <= cfg_use_def ? W'(DEF_MATCH)    : cfg_match;
                mis_r   <= cfg_use_def ? W'(DEF_MISMATCH) : cfg_mismatch;
            end
            if (calc_en) begin
                res_score <= mx;
                res_sym   <= sym;
            end
            if (load_final) final_score <= res_score;
        end
    end

    always_comb begin
        rd_en    = (state == S_RD) && !stall;
        wr_en    = ((state == S_INIT_COL) || (state == S_INIT_ROW) || (state == S_WR)) && !stall;
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        wr_score = '0;
        wr_sym   = 3'b000;
        case (state)
            S_INIT_COL: begin
                wr_score = init_score;
                wr_sym   = (i == '0) ? 3'b000 : 3'b010;
            end
            S_INIT_ROW: begin
                wr_score = init_score;
                wr_sym   = 3'b001;
            end
            S_WR: begin
                wr_score = res_score;
                wr_sym   = res_sym;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nw_fill_engine.sv
// tb/tb_nw_fill_engine.sv - directed self-checking bench for nw_fill_engine
`timescale 1ns/1ps
module tb_nw_fill_engine;

    logic              clk = 1'b0;
    logic              rst, start, cfg_use_def, stall;
    logic signed [8:0] cfg_gap, cfg_match, cfg_mismatch;
    logic [7:0]        len_a, len_b;
    logic [2:0]        a, b;
    logic signed [8:0] diag, up, left;
    logic              rd_en, wr_en, busy, done;
    logic [7:0]        i, j;
    logic signed [8:0] wr_score, final_score;
    logic [2:0]        wr_sym;

    nw_fill_engine dut (
        .clk(clk), .rst(rst), .start(start), .cfg_use_def(cfg_use_def),
        .cfg_gap(cfg_gap), .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch),
        .len_a(len_a), .len_b(len_b), .stall(stall),
        .a(a), .b(b), .diag(diag), .up(up), .left(left),
        .rd_en(rd_en), .i(i), .j(j), .wr_en(wr_en), .wr_score(wr_score),
        .wr_sym(wr_sym), .busy(busy), .done(done), .final_score(final_score)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Score RAM and sequence ROMs with one-cycle read latency
    logic signed [8:0] mem [0:128][0:128];
    logic [2:0]        seqa [0:127];
    logic [2:0]        seqb [0:127];
    logic              ovr = 1'b0;
    logic [2:0]        ov_a, ov_b;
    logic signed [8:0] ov_diag, ov_up, ov_left;

    always @(posedge clk) begin
        if (wr_en) mem[i][j] <= wr_score;
        if (rd_en) begin
            if (ovr) begin
                a <= ov_a; b <= ov_b; diag <= ov_diag; up <= ov_up; left <= ov_left;
            end else begin
                a    <= seqa[i - 8'd1];
                b    <= seqb[j - 8'd1];
                diag <= mem[i - 8'd1][j - 8'd1];
                up   <= mem[i - 8'd1][j];
                left <= mem[i][j - 8'd1];
            end
        end
    end

    logic [27:0] wq [$];
    int          rdc = 0;
    always @(negedge clk) begin
        if (wr_en) wq.push_back({i, j, wr_score, wr_sym});
        if (rd_en) rdc++;
    end

    int wbase, rbase, n, esc;

    int t1 [4][4]  = '{'{0,0,0,0}, '{1,0,-2,2}, '{0,1,-2,1}, '{1,1,1,4}};
    int t2 [12][4] = '{'{0,0,0,0}, '{1,0,-1,2}, '{2,0,-2,2}, '{0,1,-1,1}, '{0,2,-2,1},
                       '{0,3,-3,1}, '{1,1,2,4}, '{1,2,1,1}, '{1,3,0,1}, '{2,1,1,2},
                       '{2,2,4,4}, '{2,3,3,1}};

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int k, input int ei, input int ej, input int es, input int esym);
        logic [27:0]       e;
        logic signed [8:0] sc;
        if (wbase + k < wq.size()) begin
            e  = wq[wbase + k];
            sc = e[11:3];
            chk($sformatf("%s_w%0d_i", tag, k), e[27:20], ei);
            chk($sformatf("%s_w%0d_j", tag, k), e[19:12], ej);
            chk($sformatf("%s_w%0d_score", tag, k), sc, es);
            chk($sformatf("%s_w%0d_sym", tag, k), e[2:0], esym);
        end else begin
            cmp_cnt++;
            err_cnt++;
            $error("FAIL %s_w%0d_missing: observed no write expected write %0d", tag, k, k);
        end
    endtask

    task automatic run(input int la_in, input int lb_in, input bit def, input int g, input int m,
                       input int mm, input int pulse_at, input int st_at, input int st_len);
        @(negedge clk);
        len_a        = 8'(la_in);
        len_b        = 8'(lb_in);
        cfg_use_def  = def;
        cfg_gap      = 9'(g);
        cfg_match    = 9'(m);
        cfg_mismatch = 9'(mm);
        wbase        = wq.size();
        rbase        = rdc;
        start        = 1'b1;
        n            = 0;
        while (1) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (n == pulse_at);
            stall = (st_len > 0) && (n >= st_at) && (n < st_at + st_len);
            if (done) break;
            if (n >= 400) begin
                cmp_cnt++;
                err_cnt++;
                $error("FAIL run_timeout: observed no done expected done within %0d cycles", n);
                break;
            end
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; cfg_use_def = 1'b1;
        cfg_gap = '0; cfg_match = '0; cfg_mismatch = '0; len_a = '0; len_b = '0;
        a = '0; b = '0; diag = '0; up = '0; left = '0;
        ov_a = '0; ov_b = '0; ov_diag = '0; ov_up = '0; ov_left = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_final", final_score, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ij", {i, j}, 0);

        // 1x1 defaults, matching symbols
        seqa[0] = 3'd2; seqb[0] = 3'd2;
        run(1, 1, 1'b1, 0, 0, 0, 0, 0, 0);
        chk("t1_done_cycle", n, 7);
        chk("t1_final", final_score, 1);
        chk("t1_nwr", wq.size() - wbase, 4);
        chk("t1_nrd", rdc - rbase, 1);
        for (int k = 0; k < 4; k++) chk_wr("t1", k, t1[k][0], t1[k][1], t1[k][2], t1[k][3]);
        @(negedge clk);
        chk("t1_busy_after", busy, 0);

        // AG vs AGT with run-time scores
        seqa[0] = 3'd0; seqa[1] = 3'd2;
        seqb[0] = 3'd0; seqb[1] = 3'd2; seqb[2] = 3'd3;
        run(2, 3, 1'b0, -1, 2, -3, 0, 0, 0);
        chk("t2_done_cycle", n, 25);
        chk("t2_final", final_score, 3);
        chk("t2_nwr", wq.size() - wbase, 12);
        for (int k = 0; k < 12; k++) chk_wr("t2", k, t2[k][0], t2[k][1], t2[k][2], t2[k][3]);

        // three-way tie on a mismatch
        ovr = 1'b1; ov_a = 3'd1; ov_b = 3'd2; ov_diag = 9'sd0; ov_up = 9'sd1; ov_left = 9'sd1;
        run(1, 1, 1'b1, 0, 0, 0, 0, 0, 0);
        chk_wr("tie", 3, 1, 1, -1, 7);

        // diagonal saturates at the positive rail
        ov_a = 3'd3; ov_b = 3'd3; ov_diag = 9'sd255; ov_up = 9'sd0; ov_left = 9'sd0;
        run(1, 1, 1'b1, 0, 0, 0, 0, 0, 0);
        chk_wr("satd", 3, 1, 1, 255, 4);
        chk("satd_final", final_score, 255);
        ovr = 1'b0;

        // column init with length clamped to 128 and negative saturation
        run(200, 0, 1'b0, -3, 1, -1, 0, 0, 0);
        chk("sati_done_cycle", n, 130);
        chk("sati_nwr", wq.size() - wbase, 129);
        chk("sati_nrd", rdc - rbase, 0);
        for (int k = 0; k <= 128; k++) begin
            esc = (k * -3 < -256) ? -256 : k * -3;
            chk_wr("sati", k, k, 0, esc, (k == 0) ? 0 : 2);
        end

        // len_b=0 with a start pulse while busy
        run(4, 0, 1'b1, 0, 0, 0, 2, 0, 0);
        chk("lb0_done_cycle", n, 6);
        chk("lb0_nwr", wq.size() - wbase, 5);
        chk("lb0_nrd", rdc - rbase, 0);
        chk_wr("lb0", 4, 4, 0, -8, 2);
        repeat (3) @(negedge clk);
        chk("lb0_busy_after", busy, 0);
        chk("lb0_no_extra_wr", wq.size() - wbase, 5);

        // five stall cycles while in CALC
        seqa[0] = 3'd2; seqb[0] = 3'd2;
        run(1, 1, 1'b1, 0, 0, 0, 0, 5, 5);
        chk("stall_done_cycle", n, 12);
        chk("stall_nwr", wq.size() - wbase, 4);
        chk_wr("stall", 3, 1, 1, 1, 4);
        chk("stall_final", final_score, 1);

        // asynchronous reset in the middle of a fill, then a clean run
        @(negedge clk);
        len_a = 8'd2; len_b = 8'd3; cfg_use_def = 1'b0;
        cfg_gap = -9'sd1; cfg_match = 9'sd2; cfg_mismatch = -9'sd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ij", {i, j}, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_wr_en", wr_en, 0);
        chk("arst_wr_score", wr_score, 0);
        chk("arst_wr_sym", wr_sym, 0);
        chk("arst_final", final_score, 0);
        @(negedge clk);
        rst = 1'b0;
        run(1, 1, 1'b1, 0, 0, 0, 0, 0, 0);
        chk("rerun_done_cycle", n, 7);
        chk("rerun_final", final_score, 1);
        chk("rerun_nwr", wq.size() - wbase, 4);
        chk_wr("rerun", 3, 1, 1, 1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
